// File: rtl/avl_bus_wrr_arb_if.sv
// Arbiter-side bundle: per-master requests and muxed command info in; registered
// select/grant/lock out.
interface avl_bus_wrr_arb_if #(
   parameter int unsigned MASTER_NUM = 4,
   parameter int unsigned WEIGHT_W   = 4,
   parameter int unsigned BURST_W    = 8
);
   localparam int unsigned SEL_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

   logic [MASTER_NUM-1:0]          request;
   logic                           cmd_write;
   logic                           cmd_begin_burst;
   logic [BURST_W-1:0]             cmd_burst_count;
   logic                           out_request_ready;
   logic [MASTER_NUM*WEIGHT_W-1:0] weight_cfg;
   logic [SEL_W-1:0]               sel;
   logic                           grant_valid;
   logic                           locked;

   modport slave (
      input  request, cmd_write, cmd_begin_burst, cmd_burst_count,
             out_request_ready, weight_cfg,
      output sel, grant_valid, locked
   );

   modport master (
      output request, cmd_write, cmd_begin_burst, cmd_burst_count,
             out_request_ready, weight_cfg,
      input  sel, grant_valid, locked
   );
endinterface

// File: rtl/avl_bus_wrr_arb.sv
// Weighted round-robin arbiter for an N-to-1 avl_bus fabric. It holds the grant
// across write bursts and grants up to WEIGHT back-to-back commands per master per round.
module avl_bus_wrr_arb #(
   parameter int unsigned MASTER_NUM = 4,
   parameter int unsigned WEIGHT_W   = 4,
   parameter int unsigned BURST_W    = 8
) (
   input logic                clk,
   input logic                rest,
   avl_bus_wrr_arb_if.slave   bus
);
   localparam int unsigned SEL_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

   state_t                               state_q, state_d;
   logic [SEL_W-1:0]                     sel_q, sel_d;
   logic [SEL_W-1:0]                     ptr_q, ptr_d;
   logic                                 grant_valid_q, grant_valid_d;
   logic                                 locked_q, locked_d;
   logic [BURST_W-1:0]                   beat_q, beat_d;
   logic [MASTER_NUM-1:0][WEIGHT_W-1:0]  credit_q, credit_d;

   logic [MASTER_NUM-1:0][WEIGHT_W-1:0]  reload_val;
   logic [MASTER_NUM-1:0]                eligible;
   logic                                 need_reload;
   logic [SEL_W-1:0]                     winner;
   logic [SEL_W-1:0]                     sel_inc;
   logic [WEIGHT_W-1:0]                  cred_sel, cred_dec;
   logic                                 acc;
   logic                                 burst_start;

   // Reload values (0 means 1) and the eligible set used for the IDLE pick
   always_comb begin
      logic [MASTER_NUM-1:0] has_credit;
      for (int unsigned i = 0; i < MASTER_NUM; i++) begin
         reload_val[i] = (bus.weight_cfg[i*WEIGHT_W +: WEIGHT_W] == '0)
                         ? WEIGHT_W'(1) : bus.weight_cfg[i*WEIGHT_W +: WEIGHT_W];
         has_credit[i] = |credit_q[i];
      end
      need_reload = ((bus.request & has_credit) == '0);
      eligible    = need_reload ? bus.request : (bus.request & has_credit);
   end

   // First eligible master scanning upward from ptr with wrap-around
   always_comb begin
      logic         found;
      int unsigned  idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < MASTER_NUM; k++) begin
         idx = (32'(ptr_q) + k) % MASTER_NUM;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = SEL_W'(idx);
         end
      end
   end

   assign sel_inc     = (sel_q == SEL_W'(MASTER_NUM - 1)) ? '0 : sel_q + SEL_W'(1);
   assign cred_sel    = credit_q[sel_q];
   assign cred_dec    = (cred_sel == '0) ? '0 : cred_sel - WEIGHT_W'(1);
   assign acc         = grant_valid_q && bus.request[sel_q] && bus.out_request_ready;
   assign burst_start = bus.cmd_write && bus.cmd_begin_burst &&
                        (bus.cmd_burst_count > BURST_W'(1));

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      ptr_d         = ptr_q;
      grant_valid_d = grant_valid_q;
      locked_d      = locked_q;
      beat_d        = beat_q;
      credit_d      = credit_q;

      case (state_q)
         IDLE: begin
            grant_valid_d = 1'b0;
            locked_d      = 1'b0;
            if (bus.request != '0) begin
               if (need_reload) credit_d = reload_val;
               sel_d         = winner;
               grant_valid_d = 1'b1;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (!bus.request[sel_q]) begin
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end else if (acc) begin
               credit_d[sel_q] = cred_dec;
               if (burst_start) begin
                  beat_d   = bus.cmd_burst_count - BURST_W'(1);
                  locked_d = 1'b1;
                  state_d  = BURST;
               end else if (cred_dec == '0) begin
                  ptr_d         = sel_inc;
                  grant_valid_d = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         BURST: begin
            // Lock survives request drops; only accepted beats advance the count
            if (acc) begin
               beat_d = beat_q - BURST_W'(1);
               if (beat_q == BURST_W'(1)) begin
                  locked_d      = 1'b0;
                  ptr_d         = sel_inc;
                  grant_valid_d = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         default: begin
            grant_valid_d = 1'b0;
            locked_d      = 1'b0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         ptr_q         <= '0;
         grant_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         beat_q        <= '0;
         credit_q      <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         ptr_q         <= ptr_d;
         grant_valid_q <= grant_valid_d;
         locked_q      <= locked_d;
         beat_q        <= beat_d;
         credit_q      <= credit_d;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.locked      = locked_q;
endmodule

// File: tb/tb_avl_bus_wrr_arb.sv
// Scoreboard bench: each scenario queues its hand-derived accept sequence; a
// negedge monitor checks every accepted command against the queue.
module tb_avl_bus_wrr_arb;
   localparam int unsigned MN = 4;
   localparam int unsigned WW = 4;
   localparam int unsigned BW = 8;

   logic clk = 1'b0;
   logic rest;
   always #5 clk = ~clk;

   avl_bus_wrr_arb_if #(.MASTER_NUM(MN), .WEIGHT_W(WW), .BURST_W(BW)) bus();

   avl_bus_wrr_arb #(.MASTER_NUM(MN), .WEIGHT_W(WW), .BURST_W(BW)) dut (
      .clk  (clk),
      .rest (rest),
      .bus  (bus)
   );

   typedef struct {
      int unsigned sel;
      int unsigned locked;
      int unsigned gap;     // cycles since previous accept; 0 = not checked
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   int unsigned ncyc  = 0;
   int unsigned last_acc = 0;
   int          burst_m   = -1;
   int unsigned burst_len = 4;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
      end
   endtask

   task automatic exp_acc(input int unsigned s, input int unsigned l, input int unsigned g);
      exp_t e;
      e.sel = s; e.locked = l; e.gap = g;
      sbq.push_back(e);
   endtask

   // Fabric command mux model: the burst master presents a write burst
   task automatic upd_cmd();
      if (burst_m >= 0 && int'(bus.sel) == burst_m) begin
         bus.cmd_write       = 1'b1;
         bus.cmd_begin_burst = 1'b1;
         bus.cmd_burst_count = BW'(burst_len);
      end else begin
         bus.cmd_write       = 1'b0;
         bus.cmd_begin_burst = 1'b0;
         bus.cmd_burst_count = BW'(1);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      upd_cmd();
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (sbq.size() != 0 && n < maxc) begin
         cyc();
         n++;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL sb_drain pending=%0d required=0 @%0t", sbq.size(), $time);
         sbq.delete();
      end
   endtask

   task automatic reset_dut();
      rest = 1'b1;
      bus.request = '0;
      bus.out_request_ready = 1'b0;
      burst_m = -1;
      upd_cmd();
      repeat (2) @(posedge clk);
      #1;
      rest = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rest) begin
         ncyc++;
         if (bus.grant_valid && bus.request[bus.sel] && bus.out_request_ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_acc_sel", 32'(bus.sel), 99);
            end else begin
               e = sbq.pop_front();
               check("acc_sel", 32'(bus.sel), e.sel);
               check("acc_locked", 32'(bus.locked), e.locked);
               if (e.gap != 0) check("acc_gap", ncyc - last_acc, e.gap);
            end
            last_acc = ncyc;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout @%0t", $time);
      $fatal(1, "timeout");
   end

   logic [MN-1:0] s3_req [12];
   logic          s3_rdy [12];

   initial begin
      bus.weight_cfg = 16'h1111;

      // 1: reset values, 1-cycle latency, alternation with IDLE bubble
      rest = 1'b1;
      bus.request = '0;
      bus.out_request_ready = 1'b0;
      upd_cmd();
      #1;
      check("rst_sel", 32'(bus.sel), 0);
      check("rst_gv", 32'(bus.grant_valid), 0);
      check("rst_locked", 32'(bus.locked), 0);
      reset_dut();
      cyc(); cyc();
      check("idle_gv", 32'(bus.grant_valid), 0);
      bus.request = 4'b0101;
      cyc();
      check("lat_gv", 32'(bus.grant_valid), 1);
      check("lat_sel", 32'(bus.sel), 0);
      exp_acc(0, 0, 0); exp_acc(2, 0, 2); exp_acc(0, 0, 2); exp_acc(2, 0, 2);
      bus.out_request_ready = 1'b1;
      drain(30);
      bus.request = '0;

      // 2: weights m0=3, m1=1
      reset_dut();
      bus.weight_cfg = 16'h0013;
      exp_acc(0, 0, 0); exp_acc(0, 0, 1); exp_acc(0, 0, 1); exp_acc(1, 0, 2);
      exp_acc(0, 0, 2); exp_acc(0, 0, 1); exp_acc(0, 0, 1); exp_acc(1, 0, 2);
      bus.request = 4'b0011;
      bus.out_request_ready = 1'b1;
      drain(40);
      bus.request = '0;

      // 3: m1 write burst of 4 with stalls and a request drop
      reset_dut();
      bus.weight_cfg = 16'h1111;
      burst_m = 1;
      burst_len = 4;
      upd_cmd();
      s3_req = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001,
                 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
      s3_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_acc(0, 0, 0); exp_acc(1, 0, 2); exp_acc(1, 1, 3);
      exp_acc(1, 1, 2); exp_acc(1, 1, 1); exp_acc(0, 0, 2);
      for (int k = 0; k < 12; k++) begin
         bus.request = s3_req[k];
         bus.out_request_ready = s3_rdy[k];
         if (k == 5) begin
            check("burst_lock_hold", 32'(bus.locked), 1);
            check("burst_sel_hold", 32'(bus.sel), 1);
         end
         cyc();
      end
      bus.request = '0;
      burst_m = -1;
      check("burst_unlock", 32'(bus.locked), 0);
      drain(5);

      // 4: withdraw before accept; credit and ptr untouched (m2 weight 2)
      reset_dut();
      bus.weight_cfg = 16'h0211;
      bus.request = 4'b0100;
      cyc();
      check("wd_grant_sel", 32'(bus.sel), 2);
      check("wd_grant_gv", 32'(bus.grant_valid), 1);
      bus.request = 4'b0000;
      cyc();
      check("wd_gv", 32'(bus.grant_valid), 0);
      exp_acc(2, 0, 0); exp_acc(2, 0, 1); exp_acc(3, 0, 2);
      bus.request = 4'b1100;
      bus.out_request_ready = 1'b1;
      drain(20);
      bus.request = '0;

      // 5: weight 0 acts as 1; m1 weight 1->4 mid-round applies at next reload
      reset_dut();
      bus.weight_cfg = 16'h0010;
      exp_acc(0, 0, 0); exp_acc(1, 0, 2); exp_acc(0, 0, 2); exp_acc(1, 0, 2);
      exp_acc(1, 0, 1); exp_acc(1, 0, 1); exp_acc(1, 0, 1); exp_acc(0, 0, 2);
      bus.request = 4'b0011;
      bus.out_request_ready = 1'b1;
      cyc(); cyc();
      bus.weight_cfg = 16'h0040;
      drain(40);
      bus.request = '0;

      // 6: reset in the middle of a burst with two beats left
      reset_dut();
      bus.weight_cfg = 16'h1111;
      burst_m = 1;
      burst_len = 4;
      exp_acc(1, 0, 0); exp_acc(1, 1, 1);
      bus.request = 4'b0010;
      bus.out_request_ready = 1'b1;
      cyc(); cyc(); cyc();
      check("pre_rst_locked", 32'(bus.locked), 1);
      rest = 1'b1;
      #1;
      check("rst_mid_gv", 32'(bus.grant_valid), 0);
      check("rst_mid_locked", 32'(bus.locked), 0);
      check("rst_mid_sel", 32'(bus.sel), 0);
      check("rst_mid_sb", sbq.size(), 0);
      sbq.delete();
      @(posedge clk);
      #1;
      rest = 1'b0;
      burst_m = -1;
      upd_cmd();
      exp_acc(0, 0, 0); exp_acc(1, 0, 2);
      bus.request = 4'b0011;
      drain(20);
      bus.request = '0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
